trdb_packet_serializer: RTL and testbench

TRDB_PACKET_SERIALIZER -- requirements
Module: trdb_packet_serializer

---
 rtl/trdb_packet_serializer.sv | 172 +++++++++++++++++
 tb/tb_trdb_packet_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_serializer.sv
// Packet FIFO plus 32-bit word serializer for trdb packets (LSB first).
// Define TRDB_SERIALIZER_DROP_CNT_EN to add the 16-bit drop counter output.
module trdb_packet_serializer #(
    parameter int PAYLOAD_W = 256,
    parameter int LEN_W     = 6,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] packet_payload_i,
    input  logic [LEN_W-1:0]     payload_length_i,
    output logic [31:0]          data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic [3:0]           keep_o,
    output logic                 overflow_o,
    input  logic                 clear_overflow_i,
    output logic                 fifo_empty_o
`ifdef TRDB_SERIALIZER_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt_o
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int MAX_B = PAYLOAD_W / 8;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_B);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state_q, state_d;

    logic [PAYLOAD_W-1:0] pay_mem [DEPTH];
    logic [LEN_W-1:0]     len_mem [DEPTH];

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full;

    logic [PAYLOAD_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           tail_q, tail_d;

    logic [31:0]      len_ext;
    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W:0]   head_sum;
    logic             push_req, push_ok, drop, pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

    assign len_ext   = 32'(payload_length_i);
    assign len_clamp = (len_ext > 32'(MAX_B)) ? MAX_LEN : payload_length_i;

    // A pop in the same cycle frees the slot the push would otherwise lose
    assign push_req = valid_i && (payload_length_i != '0);
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign head_len = len_mem[rd_idx];
    assign head_sum = {1'b0, head_len} + (LEN_W+1)'(3);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    shreg_d = shreg_q >> 32;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shreg_d = pay_mem[rd_idx];
            cnt_d   = LEN_W'(head_sum >> 2);
            tail_d  = head_len[1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            pay_mem[wr_idx] <= packet_payload_i;
            len_mem[wr_idx] <= len_clamp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            tail_q     <= '0;
            overflow_o <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

`ifdef TRDB_SERIALIZER_DROP_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (drop) begin
            if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end else if (clear_overflow_i) begin
            drop_cnt_o <= '0;
        end
    end
`endif

    assign valid_o      = (state_q == SEND);
    assign data_o       = shreg_q[31:0];
    assign last_o       = valid_o && (cnt_q == LEN_W'(1));
    assign fifo_empty_o = empty;

    always_comb begin
        keep_o = 4'h0;
        if (valid_o) begin
            keep_o = 4'hF;
            if (last_o) begin
                unique case (tail_q)
                    2'd1:    keep_o = 4'b0001;
                    2'd2:    keep_o = 4'b0011;
                    2'd3:    keep_o = 4'b0111;
                    default: keep_o = 4'b1111;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// Randomized bench for trdb_packet_serializer with a queue-based packet model.
// Directed cases pin the model with literal expectations.
module tb_trdb_packet_serializer;

    localparam int PW    = 256;
    localparam int LW    = 6;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic [PW-1:0] packet_payload_i = '0;
    logic [LW-1:0] payload_length_i = '0;
    logic [31:0]   data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          last_o;
    logic [3:0]    keep_o;
    logic          overflow_o;
    logic          clear_overflow_i = 1'b0;
    logic          fifo_empty_o;
`ifdef TRDB_SERIALIZER_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    trdb_packet_serializer #(
        .PAYLOAD_W(PW),
        .LEN_W(LW),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .valid_i(valid_i),
        .packet_payload_i(packet_payload_i),
        .payload_length_i(payload_length_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .last_o(last_o),
        .keep_o(keep_o),
        .overflow_o(overflow_o),
        .clear_overflow_i(clear_overflow_i),
        .fifo_empty_o(fifo_empty_o)
`ifdef TRDB_SERIALIZER_DROP_CNT_EN
        ,
        .drop_cnt_o(drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [PW-1:0] p;
        int            len;
    } pkt_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    pkt_t  q[$];
    word_t cur[$];
    logic  m_ovf = 1'b0;
    int    m_drop = 0;
    int    total = 0;
    int    bad = 0;
    bit    en_cmp = 1'b0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expand(input pkt_t pk);
        int n;
        word_t w;
        n = (pk.len + 3) / 4;
        for (int i = 0; i < n; i++) begin
            w.d = pk.p[32*i +: 32];
            w.l = (i == n - 1);
            w.k = (w.l && (pk.len % 4) != 0) ? 4'((1 << (pk.len % 4)) - 1) : 4'hF;
            cur.push_back(w);
        end
    endfunction

    // Transaction-level model: a packet queue plus the words still to send
    always @(posedge clk_i) begin
        bit   busy, hs, last_hs, do_pop, push_req, dropped;
        pkt_t pk;
        if (!rst_ni) begin
            q.delete();
            cur.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            busy     = cur.size() > 0;
            hs       = busy && ready_i;
            last_hs  = hs && cur.size() == 1;
            do_pop   = (!busy || last_hs) && q.size() > 0;
            push_req = valid_i && payload_length_i != 0;
            dropped  = push_req && q.size() >= DEPTH && !do_pop;
            if (hs) void'(cur.pop_front());
            if (do_pop) begin
                pk = q.pop_front();
                expand(pk);
            end
            if (push_req && !dropped) begin
                pk.p   = packet_payload_i;
                pk.len = (int'(payload_length_i) > PW / 8) ? PW / 8 : int'(payload_length_i);
                q.push_back(pk);
            end
            if (dropped) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else if (clear_overflow_i) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (en_cmp) begin
            chk("valid_o", valid_o, cur.size() > 0);
            chk("fifo_empty_o", fifo_empty_o, q.size() == 0);
            chk("overflow_o", overflow_o, m_ovf);
`ifdef TRDB_SERIALIZER_DROP_CNT_EN
            chk("drop_cnt_o", drop_cnt_o, 16'(m_drop));
`endif
            if (cur.size() > 0) begin
                chk("data_o", data_o, cur[0].d);
                chk("keep_o", keep_o, cur[0].k);
                chk("last_o", last_o, cur[0].l);
            end
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic push(input logic [PW-1:0] p, input int len);
        valid_i          = 1'b1;
        packet_payload_i = p;
        payload_length_i = LW'(len);
    endtask

    task automatic drain_count(output int words, output int lasts);
        words = 0;
        lasts = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin
                words++;
                if (last_o) lasts++;
            end
            tick();
        end
    endtask

    initial begin
        int w, l;
        logic [PW-1:0] rp;
        tick();
        tick();
        chk("rst valid_o", valid_o, 1'b0);
        chk("rst fifo_empty_o", fifo_empty_o, 1'b1);
        chk("rst data_o", data_o, 32'h0);
        chk("rst keep_o", keep_o, 4'h0);
        chk("rst last_o", last_o, 1'b0);
        chk("rst overflow_o", overflow_o, 1'b0);
        rst_ni = 1'b1;
        en_cmp = 1'b1;

        ready_i = 1'b1;
        push(PW'(48'h665544332211), 6);
        tick();
        valid_i = 1'b0;
        chk("len6 queued", fifo_empty_o, 1'b0);
        tick();
        chk("len6 w0 valid", valid_o, 1'b1);
        chk("len6 w0 data", data_o, 32'h44332211);
        chk("len6 w0 keep", keep_o, 4'b1111);
        chk("len6 w0 last", last_o, 1'b0);
        tick();
        chk("len6 w1 data", data_o, 32'h00006655);
        chk("len6 w1 keep", keep_o, 4'b0011);
        chk("len6 w1 last", last_o, 1'b1);
        tick();
        chk("len6 done", valid_o, 1'b0);

        push(PW'(48'h665544332211), 6);
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall data", data_o, 32'h44332211);
            chk("stall valid", valid_o, 1'b1);
        end
        ready_i = 1'b1;
        tick();
        chk("stall w1 data", data_o, 32'h00006655);
        tick();
        chk("stall done", valid_o, 1'b0);

        // One packet moves into the shift register, four fill the FIFO, the sixth drops
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(PW'(32'hA0000000 + i), 4);
            tick();
        end
        valid_i = 1'b0;
        chk("ovf set", overflow_o, 1'b1);
`ifdef TRDB_SERIALIZER_DROP_CNT_EN
        chk("drop cnt", drop_cnt_o, 16'd1);
`endif
        ready_i = 1'b1;
        drain_count(w, l);
        chk("ovf drain words", 32'(w), 32'd5);
        chk("ovf drain lasts", 32'(l), 32'd5);
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        chk("ovf cleared", overflow_o, 1'b0);

        ready_i = 1'b0;
        push(PW'(64'h8877665544332211), 8);
        tick();
        push(PW'(32'hDDCCBBAA), 4);
        tick();
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("b2b w1 last", last_o, 1'b0);
        tick();
        chk("b2b w2 valid", valid_o, 1'b1);
        chk("b2b w2 last", last_o, 1'b1);
        tick();
        chk("b2b w3 valid", valid_o, 1'b1);
        chk("b2b w3 data", data_o, 32'hDDCCBBAA);
        chk("b2b w3 last", last_o, 1'b1);
        tick();
        chk("b2b done", valid_o, 1'b0);

        push(PW'(32'h12345678), 0);
        tick();
        valid_i = 1'b0;
        chk("len0 empty", fifo_empty_o, 1'b1);
        tick();
        chk("len0 valid", valid_o, 1'b0);
        for (int i = 0; i < 8; i++) rp[32*i +: 32] = $urandom();
        push(rp, 40);
        tick();
        valid_i = 1'b0;
        drain_count(w, l);
        chk("len40 words", 32'(w), 32'd8);

        push(rp, 32);
        tick();
        push(PW'(64'h1), 8);
        tick();
        valid_i = 1'b0;
        tick();
        chk("mid w1 valid", valid_o, 1'b1);
        chk("mid w1 data", data_o, rp[63:32]);
        rst_ni = 1'b0;
        tick();
        chk("mid rst valid", valid_o, 1'b0);
        chk("mid rst empty", fifo_empty_o, 1'b1);
        chk("mid rst ovf", overflow_o, 1'b0);
        rst_ni = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) packet_payload_i[32*i +: 32] = $urandom();
            valid_i          = ($urandom_range(0, 1) == 1);
            payload_length_i = LW'($urandom_range(0, 40));
            ready_i          = ($urandom_range(0, 9) < 6);
            clear_overflow_i = ($urandom_range(0, 19) == 0);
            rst_ni           = ($urandom_range(0, 299) != 0);
            tick();
        end
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
